// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  // rx_valid is a one-cycle strobe with no ready: rx_data and both error flags are
  // updated on that same cycle and hold until the next frame completes.

  localparam int CW  = $clog2(CLK_PER_BIT);
  localparam int MID = CLK_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC = MID + 1;
`else
  localparam int START_DEC = MID;
`endif
  localparam logic [CW-1:0] START_TICK = CW'(START_DEC);
  localparam logic [CW-1:0] BIT_TICK   = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t state, state_nxt;

  logic                 sync1, rxd_s, rxd_q;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_acc, pe_acc;
  logic                 fall, tick, bit_val;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
      rxd_q <= rxd_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rxd_s one cycle ago, hist[1] two cycles ago: the vote spans decision-2..decision.
  logic [1:0] hist;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) hist <= 2'b11;
    else        hist <= {hist[0], rxd_s};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  assign fall = rxd_q & ~rxd_s;
  // START decides at mid-bit and restarts the counter there, so later bits decide at CLK_PER_BIT-1.
  assign tick = (state == S_START) ? (cnt == START_TICK) : (cnt == BIT_TICK);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START:  if (tick) state_nxt = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (tick && idx == LAST_DATA) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (tick && idx == LAST_STOP) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      fe_acc     <= 1'b0;
      pe_acc     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == S_IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (fall) begin
            fe_acc <= 1'b0;
            pe_acc <= 1'b0;
            idx    <= '0;
          end
        end
        S_START: idx <= '0;
        S_DATA: begin
          if (tick) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            idx   <= (idx == LAST_DATA) ? 4'd0 : idx + 4'd1;
          end
        end
        S_PARITY: begin
          if (tick) pe_acc <= (PARITY == 1) ? ~(^shreg ^ bit_val) : (^shreg ^ bit_val);
        end
        S_STOP: begin
          if (tick) begin
            if (idx == LAST_STOP) begin
              rx_valid   <= 1'b1;
              rx_data    <= shreg;
              frame_err  <= fe_acc | ~bit_val;
              parity_err <= pe_acc;
              idx        <= '0;
            end else begin
              fe_acc <= fe_acc | ~bit_val;
              idx    <= idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
